// File: rtl/freq_meter_pkg.sv
// Shared types and constant helpers for the frequency-meter gate sequencer.
package freq_meter_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD} state_t;

  localparam int NUM_DIGITS = 6;
  localparam int RANGE_MAX  = 2;

  // Gate length for range r; only ever evaluated on elaboration constants.
  function automatic int gate_len(input int gate_cycles, input int r);
    int len;
    len = gate_cycles;
    for (int i = 0; i < r; i++) len = len / 10;
    return len;
  endfunction

  // One timer serves both the gate and the hold interval, so size it for the longer one.
  function automatic int timer_width(input int gate_cycles, input int hold_cycles);
    int longest;
    longest = (gate_cycles > hold_cycles) ? gate_cycles : hold_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Counter-chain and result bundle between the gate sequencer and its neighbours.
interface freq_gate_ctrl_if #(
  parameter int NUM_DIGITS = freq_meter_pkg::NUM_DIGITS
);
  logic                    cnt_en;
  logic                    cnt_clr;
  logic [4*NUM_DIGITS-1:0] cnt_data;
  logic                    cnt_cout;
  logic [4*NUM_DIGITS-1:0] result;
  logic [1:0]              result_range;
  logic                    result_ovf;
  logic                    result_valid;

  modport master (
    output cnt_en, cnt_clr, result, result_range, result_ovf, result_valid,
    input  cnt_data, cnt_cout
  );

  modport slave (
    input  cnt_en, cnt_clr, result, result_range, result_ovf, result_valid,
    output cnt_data, cnt_cout
  );
endinterface

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down-counter; done is high on the last cycle of an enabled interval.
module gate_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (en && (count_reg != '0)) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A load of N yields exactly N enabled cycles; a load of 0 behaves like 1.
  assign done = en && (count_reg <= WIDTH'(1));
endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency-meter measurement sequencer: clear, gate, settle, latch, hold.
// Define AUTO_RANGE_EN to auto-range the gate from 1 s down to 10 ms.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int NUM_DIGITS  = freq_meter_pkg::NUM_DIGITS
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             run,
  input  logic [1:0]       range_sel,
  output logic             busy,
  freq_gate_ctrl_if.master cnt_bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int TW = timer_width(GATE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] LEN0 = TW'(gate_len(GATE_CYCLES, 0));
  localparam logic [TW-1:0] LEN1 = TW'(gate_len(GATE_CYCLES, 1));
  localparam logic [TW-1:0] LEN2 = TW'(gate_len(GATE_CYCLES, 2));
  localparam logic [TW-1:0] HOLD_LOAD = TW'((HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES);

  state_t          state_reg, state_next;
  logic [1:0]      range_reg, range_next;
  logic [1:0]      gate_range;
  logic            ovf_seen_reg, ovf_seen_next;
  logic [DW-1:0]   result_reg;
  logic [1:0]      result_range_reg;
  logic            result_ovf_reg;
  logic            result_valid_reg;
  logic            timer_load, timer_en, timer_done;
  logic [TW-1:0]   timer_load_val;
  logic [TW-1:0]   gate_len_sel;

`ifdef AUTO_RANGE_EN
  logic unused_range_sel;
  assign unused_range_sel = ^range_sel;
  assign gate_range = range_reg;

  // Overflow widens the range (shorter gate); a blank top digit narrows it.
  always_comb begin
    range_next = range_reg;
    if (state_reg == LATCH) begin
      if (ovf_seen_reg && (range_reg < 2'(RANGE_MAX))) begin
        range_next = range_reg + 2'd1;
      end else if (!ovf_seen_reg && (cnt_bus.cnt_data[DW-1 -: 4] == 4'd0) && (range_reg != 2'd0)) begin
        range_next = range_reg - 2'd1;
      end
    end
  end
`else
  assign gate_range = (range_sel > 2'(RANGE_MAX)) ? 2'(RANGE_MAX) : range_sel;
  assign range_next = (state_reg == CLEAR) ? gate_range : range_reg;
`endif

  always_comb begin
    case (gate_range)
      2'd0:    gate_len_sel = LEN0;
      2'd1:    gate_len_sel = LEN1;
      default: gate_len_sel = LEN2;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    timer_load     = 1'b0;
    timer_load_val = gate_len_sel;
    timer_en       = 1'b0;
    ovf_seen_next  = ovf_seen_reg;
    case (state_reg)
      IDLE: begin
        if (run) state_next = CLEAR;
      end
      CLEAR: begin
        ovf_seen_next = 1'b0;
        timer_load    = 1'b1;
        state_next    = run ? GATE : IDLE;
      end
      GATE: begin
        timer_en      = 1'b1;
        ovf_seen_next = ovf_seen_reg | cnt_bus.cnt_cout;
        if (!run) begin
          state_next = IDLE;
        end else if (timer_done) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        // The chain's last carry can still arrive here.
        ovf_seen_next = ovf_seen_reg | cnt_bus.cnt_cout;
        state_next    = LATCH;
      end
      LATCH: begin
        timer_load     = 1'b1;
        timer_load_val = HOLD_LOAD;
        state_next     = HOLD;
      end
      HOLD: begin
        timer_en = 1'b1;
        if (timer_done) state_next = run ? CLEAR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg        <= IDLE;
      range_reg        <= 2'd0;
      ovf_seen_reg     <= 1'b0;
      result_reg       <= '0;
      result_range_reg <= 2'd0;
      result_ovf_reg   <= 1'b0;
      result_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      range_reg        <= range_next;
      ovf_seen_reg     <= ovf_seen_next;
      result_valid_reg <= (state_reg == LATCH);
      if (state_reg == LATCH) begin
        result_reg       <= cnt_bus.cnt_data;
        result_range_reg <= range_reg;
        result_ovf_reg   <= ovf_seen_reg;
      end
    end
  end

  gate_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .srst     (Rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  assign cnt_bus.cnt_en       = (state_reg == GATE);
  assign cnt_bus.cnt_clr      = (state_reg == CLEAR);
  assign cnt_bus.result       = result_reg;
  assign cnt_bus.result_range = result_range_reg;
  assign cnt_bus.result_ovf   = result_ovf_reg;
  assign cnt_bus.result_valid = result_valid_reg;
  assign busy                 = (state_reg != IDLE);
endmodule
